// File: rtl/axis_merge_pkg.sv
// rtl/axis_merge_pkg.sv - output word field layout and packing helper for the stream merger
package axis_merge_pkg;

  localparam int DATA_W   = 16;
  localparam int OUT_W    = 32;
  localparam int CH_ID_W  = 4;
  localparam int SEQ_W    = 12;

  localparam int DATA_LSB = 0;
  localparam int SEQ_LSB  = 16;
  localparam int CH_LSB   = 28;

  function automatic logic [OUT_W-1:0] pack_word(
    input logic [CH_ID_W-1:0] ch,
    input logic [SEQ_W-1:0]   seq,
    input logic [DATA_W-1:0]  data
  );
    logic [OUT_W-1:0] w;
    w = '0;
    w[CH_LSB   +: CH_ID_W] = ch;
    w[SEQ_LSB  +: SEQ_W]   = seq;
    w[DATA_LSB +: DATA_W]  = data;
    return w;
  endfunction

endpackage

// File: rtl/axis_rr_merge_16_to_32_rr_pick.sv
// rtl/axis_rr_merge_16_to_32_rr_pick.sv - combinational circular priority picker
// The search starts one past last_grant and wraps, so the previous winner has lowest priority.
module rr_pick
  import axis_merge_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic [NUM_CH-1:0]  req,
  input  logic [CH_ID_W-1:0] last_grant,
  output logic               grant_valid,
  output logic [CH_ID_W-1:0] grant
);

  int idx;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!grant_valid && (idx == i) && req[i]) begin
          grant_valid = 1'b1;
          grant       = CH_ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/axis_rr_merge_16_to_32.sv
// rtl/axis_rr_merge_16_to_32.sv - round-robin merge of NUM_CH 16-bit streams onto one tagged 32-bit stream
// Muted channels are drained (always ready) and never take a sequence number or move the pointer.
module axis_rr_merge_16_to_32
  import axis_merge_pkg::*;
#(
  parameter int NUM_CH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_enable,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  output logic [OUT_W-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready
);

  localparam logic [CH_ID_W-1:0] LAST_INIT = CH_ID_W'(NUM_CH - 1);

  logic               load;
  logic [NUM_CH-1:0]  req;
  logic               grant_valid;
  logic [CH_ID_W-1:0] grant;
  logic [CH_ID_W-1:0] last_grant;
  logic [SEQ_W-1:0]   seq;
  logic [DATA_W-1:0]  sel_data;

  assign load = !m_axis_tvalid || m_axis_tready;
  assign req  = s_axis_tvalid & ch_enable;

  rr_pick #(
    .NUM_CH(NUM_CH)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  always_comb begin
    sel_data      = '0;
    s_axis_tready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant == CH_ID_W'(i)) begin
        sel_data = s_axis_tdata[i*DATA_W +: DATA_W];
      end
      s_axis_tready[i] = !rst && (!ch_enable[i] ||
                                  (load && grant_valid && (grant == CH_ID_W'(i))));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      seq           <= '0;
      last_grant    <= LAST_INIT;
    end else if (load) begin
      if (grant_valid) begin
        m_axis_tdata  <= pack_word(grant, seq, sel_data);
        m_axis_tvalid <= 1'b1;
        last_grant    <= grant;
        seq           <= seq + 1'b1;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_merge_16_to_32.sv
// tb/tb_axis_rr_merge_16_to_32.sv - self-checking bench for the round-robin stream merger
module tb_axis_rr_merge_16_to_32;

  localparam int N = 3;

  logic        clk;
  logic        rst;
  logic [2:0]  ch_enable;
  logic [47:0] s_axis_tdata;
  logic [2:0]  s_axis_tvalid;
  logic [2:0]  s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [15:0] din [3];

  int n_checks = 0;
  int n_errors = 0;

  assign s_axis_tdata = {din[2], din[1], din[0]};

  axis_rr_merge_16_to_32 #(.NUM_CH(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_enable    (ch_enable),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: delivered word = {channel, count of words delivered since reset, data}.
  bit          model_on = 1'b0;
  bit          mv = 1'b0;
  logic [31:0] md = '0;
  int          mlast = N - 1;
  int          mseq = 0;

  function automatic int model_grant();
    int best = -1;
    int bestd = N;
    int d;
    for (int i = 0; i < N; i++) begin
      if (s_axis_tvalid[i] && ch_enable[i]) begin
        d = (i - mlast - 1 + 2 * N) % N;
        if (d < bestd) begin
          bestd = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pre();
    int g;
    logic [2:0] rdy;
    @(negedge clk);
    if (model_on) begin
      g = model_grant();
      rdy = 3'b000;
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          rdy[i] = !ch_enable[i] || ((!mv || m_axis_tready) && (g == i));
        end
      end
      chk("model_tready", {29'b0, s_axis_tready}, {29'b0, rdy});
      chk("model_tvalid", {31'b0, m_axis_tvalid}, {31'b0, mv});
      chk("model_tdata", m_axis_tdata, md);
    end
  endtask

  task automatic post();
    int g;
    g = model_grant();
    @(posedge clk);
    if (rst) begin
      mv = 1'b0;
      md = '0;
      mseq = 0;
      mlast = N - 1;
    end else if (!mv || m_axis_tready) begin
      if (g >= 0) begin
        md = (32'(g) << 28) | (32'(mseq) << 16) | 32'(din[g]);
        mv = 1'b1;
        mlast = g;
        mseq = (mseq + 1) % 4096;
      end else begin
        mv = 1'b0;
      end
    end
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [2:0]  en;
    logic [2:0]  valid;
    logic        mt;
    logic [15:0] d0, d1, d2;
    logic        chk_out;
    logic [2:0]  exp_rdy;
    logic        exp_mv;
    logic [31:0] exp_md;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [2:0]  rdy_e;
    logic [31:0] w_e;
    int gk, gp;

    vecs[0]  = '{1'b1, 3'b111, 3'b000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 3'b000, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 3'b111, 3'b000, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b1, 3'b000, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 3'b111, 3'b010, 1'b1, 16'h0000, 16'h8001, 16'h0000, 1'b1, 3'b010, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 3'b111, 3'b000, 1'b1, 16'h0000, 16'h8001, 16'h0000, 1'b1, 3'b000, 1'b1, 32'h1000_8001};
    vecs[4]  = '{1'b0, 3'b111, 3'b000, 1'b1, 16'h0000, 16'h8001, 16'h0000, 1'b1, 3'b000, 1'b0, 32'h1000_8001};
    vecs[5]  = '{1'b1, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b000, 1'b0, 32'h1000_8001};
    vecs[6]  = '{1'b0, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b001, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b010, 1'b1, 32'h0000_A000};
    vecs[8]  = '{1'b0, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b100, 1'b1, 32'h1001_B001};
    vecs[9]  = '{1'b0, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b001, 1'b1, 32'h2002_C002};
    vecs[10] = '{1'b0, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b010, 1'b1, 32'h0003_A000};
    vecs[11] = '{1'b0, 3'b111, 3'b111, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b100, 1'b1, 32'h1004_B001};
    vecs[12] = '{1'b0, 3'b111, 3'b000, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b000, 1'b1, 32'h2005_C002};
    vecs[13] = '{1'b0, 3'b111, 3'b000, 1'b1, 16'hA000, 16'hB001, 16'hC002, 1'b1, 3'b000, 1'b0, 32'h2005_C002};

    rst = 1'b1; ch_enable = 3'b111; s_axis_tvalid = 3'b000; m_axis_tready = 1'b1;
    din[0] = '0; din[1] = '0; din[2] = '0;

    // Reset, single word from ch1, then full-rate round robin after a second reset.
    for (int r = 0; r < 14; r++) begin
      rst = vecs[r].rst; ch_enable = vecs[r].en; s_axis_tvalid = vecs[r].valid;
      m_axis_tready = vecs[r].mt;
      din[0] = vecs[r].d0; din[1] = vecs[r].d1; din[2] = vecs[r].d2;
      pre();
      chk($sformatf("vec%0d_tready", r), {29'b0, s_axis_tready}, {29'b0, vecs[r].exp_rdy});
      if (vecs[r].chk_out) begin
        chk($sformatf("vec%0d_tvalid", r), {31'b0, m_axis_tvalid}, {31'b0, vecs[r].exp_mv});
        chk($sformatf("vec%0d_tdata", r), m_axis_tdata, vecs[r].exp_md);
      end
      post();
    end

    // Back-pressure: seq=6, last grant ch2.
    s_axis_tvalid = 3'b001; din[0] = 16'h1111; m_axis_tready = 1'b0;
    pre(); chk("bp_first_tready", {29'b0, s_axis_tready}, 32'h1); post();
    s_axis_tvalid = 3'b111; din[0] = 16'h2222; din[1] = 16'h3333; din[2] = 16'h4444;
    for (int k = 0; k < 5; k++) begin
      pre();
      chk("bp_stall_tready", {29'b0, s_axis_tready}, 32'h0);
      chk("bp_stall_tvalid", {31'b0, m_axis_tvalid}, 32'h1);
      chk("bp_stall_tdata", m_axis_tdata, 32'h0006_1111);
      post();
    end
    m_axis_tready = 1'b1;
    pre();
    chk("bp_release_tready", {29'b0, s_axis_tready}, 32'h2);
    chk("bp_release_tdata", m_axis_tdata, 32'h0006_1111);
    post();
    s_axis_tvalid = 3'b000;
    pre(); chk("bp_next_word", m_axis_tdata, 32'h1007_3333); post();

    // Muting ch1: seq=8, last grant ch1.
    ch_enable = 3'b101; s_axis_tvalid = 3'b111;
    din[0] = 16'h5555; din[1] = 16'h6666; din[2] = 16'h7777;
    for (int k = 0; k < 6; k++) begin
      pre();
      gk = (k % 2 == 0) ? 2 : 0;
      rdy_e = 3'b010 | 3'(1 << gk);
      chk("mute_tready", {29'b0, s_axis_tready}, {29'b0, rdy_e});
      if (k > 0) begin
        gp = (k % 2 == 1) ? 2 : 0;
        w_e = (32'(gp) << 28) | (32'(8 + k - 1) << 16) | ((gp == 2) ? 32'h7777 : 32'h5555);
        chk("mute_word", m_axis_tdata, w_e);
      end
      post();
    end
    s_axis_tvalid = 3'b000;
    pre();
    chk("mute_idle_tready", {29'b0, s_axis_tready}, 32'h2);
    chk("mute_last_word", m_axis_tdata, 32'h000D_5555);
    post();
    ch_enable = 3'b111;

    // Sequence wrap over 4097 words.
    rst = 1'b1; pre(); post(); rst = 1'b0;
    for (int c = 0; c <= 4097; c++) begin
      s_axis_tvalid = (c < 4097) ? 3'b111 : 3'b000;
      pre();
      if (c == 4096) begin
        chk("wrap_word4095", {16'b0, m_axis_tdata[31:16]}, 32'h0FFF);
        chk("wrap_valid4095", {31'b0, m_axis_tvalid}, 32'h1);
      end
      if (c == 4097) begin
        chk("wrap_word4096", {16'b0, m_axis_tdata[31:16]}, 32'h1000);
      end
      post();
    end

    // Reset while a word is stalled.
    s_axis_tvalid = 3'b001; din[0] = 16'h9999; m_axis_tready = 1'b0;
    pre(); post();
    s_axis_tvalid = 3'b000;
    pre(); chk("rst_stall_pending", {31'b0, m_axis_tvalid}, 32'h1); post();
    rst = 1'b1;
    pre(); chk("rst_stall_tready", {29'b0, s_axis_tready}, 32'h0); post();
    rst = 1'b0; s_axis_tvalid = 3'b111; din[0] = 16'hAAAA; m_axis_tready = 1'b1;
    pre();
    chk("rst_stall_dropped", {31'b0, m_axis_tvalid}, 32'h0);
    chk("rst_stall_grant0", {29'b0, s_axis_tready}, 32'h1);
    post();
    s_axis_tvalid = 3'b000;
    pre(); chk("rst_stall_first_word", m_axis_tdata, 32'h0000_AAAA); post();

    // Randomized traffic against the reference model.
    rst = 1'b1; pre(); post();
    model_on = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      ch_enable = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      s_axis_tvalid = 3'($urandom);
      m_axis_tready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) din[i] = 16'($urandom);
      pre();
      post();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_rr_merge_16_to_32.md
Name: axis_rr_merge_16_to_32

Overview:
Round-robin scheduler that shares the single 32-bit MicroBlaze AXI-stream slave port between NUM_CH 16-bit DSP/SPI streams (default: raw ECG, band-pass output, QRS-detect output). It grants one input word per transfer, tags the word with its channel ID and a running sequence number, and holds it in a registered output stage. Per-channel enables let software mute a stream, and a muted stream is drained instead of back-pressured.

Parameters:
NUM_CH, 3, number of 16-bit input streams (legal range 1..16).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
ch_enable  in  NUM_CH  per-channel enable; bit i=0 mutes channel i.
s_axis_tdata  in  NUM_CH*16  flattened signed inputs; channel i occupies [16i+15:16i].
s_axis_tvalid  in  NUM_CH  per-channel valid.
s_axis_tready  out  NUM_CH  per-channel ready.
m_axis_tdata  out  32  {ch_id[3:0], seq[11:0], data[15:0]}.
m_axis_tvalid  out  1  output word valid.
m_axis_tready  in  1  MicroBlaze ready.

Behaviour:
- Reset values: m_axis_tvalid=0; m_axis_tdata=0; seq=0; round-robin pointer last_grant=NUM_CH-1, so channel 0 has first priority. s_axis_tready is combinational and is 0 while rst=1.
- load = !m_axis_tvalid || m_axis_tready. The output stage accepts a new word only when load=1.
- Candidate set: s_axis_tvalid[i] && ch_enable[i].
- When load=1, search the candidate set circularly, starting at last_grant+1 and wrapping at NUM_CH-1 -> 0.
  - The first candidate found is grant index g. s_axis_tready[g]=1 in the same cycle.
  - On that edge: m_axis_tdata <= {g[3:0], seq, s_axis_tdata[g]}; m_axis_tvalid <= 1; last_grant <= g; seq <= seq+1.
- If load=1 and no candidate exists: m_axis_tvalid <= 0. last_grant and seq are unchanged.
- Only one enabled channel may see s_axis_tready=1 in any cycle.
- Muted channels (ch_enable[i]=0):
  - s_axis_tready[i]=1 every cycle, not in reset.
  - Their words are discarded.
  - They never consume a sequence number or move last_grant.
- Latency: an accepted input appears on m_axis_* on the next cycle. Sustained throughput is 1 word/cycle while m_axis_tready=1.
- AXIS stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata holds stable. All enabled s_axis_tready bits are 0 during this stall.
- Fairness: with all channels valid and enabled, grants cycle 0,1,...,NUM_CH-1,0,... Starvation bound is NUM_CH-1 grants.
- seq is 12 bits and wraps 4095 -> 0. It counts delivered-to-register words only.
- A ch_enable change takes effect in the next arbitration cycle. A word already in the output register is still delivered with its original tag.
- Reset mid-transfer: a pending output word is dropped. The next grant starts at channel 0 with seq=0.
- The data field is passed through unmodified. Sign/magnitude is interpreted by software using ch_id.

Decomposition:
- Package axis_merge_pkg:
  - Widths: DATA_W=16, OUT_W=32, CH_ID_W=4, SEQ_W=12.
  - Field offsets: DATA_LSB=0, SEQ_LSB=16, CH_LSB=28.
  - Function pack_word(ch, seq, data).
- Sub-module rr_pick:
  - Purely combinational circular priority picker.
  - Inputs: request vector, last_grant.
  - Outputs: grant_valid, grant index.
- The top level holds the output register, seq counter, last_grant and the tready decode.

Test Plan:
- Reset, then single channel: assert rst 2 cycles; ch1 sends 16'h8001 with m_axis_tready=1 -> next cycle m_axis_tdata=32'h1000_8001 and m_axis_tvalid=1; then seq=1.
- All 3 channels continuously valid and enabled, m_axis_tready=1 -> ch_id sequence 0,1,2,0,1,2 with seq 0..5; exactly one s_axis_tready high per cycle.
- Back-pressure: hold m_axis_tready=0 for 5 cycles with a word pending -> m_axis_tdata unchanged and all s_axis_tready=0; on release the word is accepted and the next grant goes to the following channel.
- Muting: ch_enable=3'b101 with all channels valid -> ch1 tready=1 every cycle, no ch_id=1 words on the output, grants alternate 0,2; seq has no gaps.
- Seq wrap: force 4097 accepted words -> word 4095 carries seq=12'hFFF and word 4096 carries seq=0.
- Reset mid-stall: pending word with m_axis_tready=0, assert rst 1 cycle -> m_axis_tvalid=0; after release the first grant is ch0 with seq=0.
